// File: rtl/etc_semiring_pipe_if.sv
// etc_semiring_pipe_if
//    Operand/result handshake bundle for the semiring tensor pipe.
//    master : producer of operands and consumer of results (staging/writeback side)
//    slave  : the pipe itself
//    in_valid/in_ready, op, acc_en, inA/inB/inC : operand transfer
//    out_valid/out_ready, out, out_err           : result transfer
//    Matrices are NxN row-major, element [i][j] at bit offset (i*N+j)*W.
interface etc_semiring_pipe_if #(
   parameter int W = 16,
   parameter int N = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         op;
   logic               acc_en;
   logic [N*N*W-1:0]   inA;
   logic [N*N*W-1:0]   inB;
   logic [N*N*W-1:0]   inC;
   logic               out_valid;
   logic               out_ready;
   logic [N*N*W-1:0]   out;
   logic               out_err;

   modport master (
      output in_valid, op, acc_en, inA, inB, inC, out_ready,
      input  in_ready, out_valid, out, out_err
   );

   modport slave (
      input  in_valid, op, acc_en, inA, inB, inC, out_ready,
      output in_ready, out_valid, out, out_err
   );
endinterface

// File: rtl/etc_semiring_pipe.sv
// etc_semiring_pipe
//    Three-stage NxN matrix engine: D = C' (+) (A (x) B) over a selectable
//    semiring, or squared-L2 distance, on W-bit unsigned elements.
//    S1 registers operands, S2 registers all N^3 pairwise terms,
//    S3 registers the per-element reduction. One result per cycle,
//    global stall when the result is held by the consumer.
// Ports:
//    clk    : clock, rising edge
//    rst_n  : asynchronous active-low reset
//    bus    : etc_semiring_pipe_if.slave (operand and result handshakes)
//    perf_ops, perf_stall : 32-bit counters, only with ETC_PERF_CNT_EN
// Build option:
//    ETC_PERF_CNT_EN : adds output-transfer and stall-cycle counters.
module etc_semiring_pipe #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   etc_semiring_pipe_if.slave bus
`ifdef ETC_PERF_CNT_EN
   ,
   output logic [31:0]        perf_ops,
   output logic [31:0]        perf_stall
`endif
);

   localparam int NN  = N * N;
   localparam int NNN = N * N * N;
   localparam int VW  = NN * W;

   localparam logic [2:0] OP_PT     = 3'b000;
   localparam logic [2:0] OP_L2     = 3'b001;
   localparam logic [2:0] OP_MINP   = 3'b010;
   localparam logic [2:0] OP_MAXP   = 3'b011;
   localparam logic [2:0] OP_MINMAX = 3'b100;
   localparam logic [2:0] OP_MAXMIN = 3'b101;
   localparam logic [2:0] OP_ORAND  = 3'b110;
   localparam logic [2:0] OP_RSV    = 3'b111;

   localparam logic [W-1:0] INF = '1;

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (a == INF || b == INF || s[W]) return INF;
      return s[W-1:0];
   endfunction

   // Semiring product; the L2 path squares the absolute difference so the
   // subtraction never wraps before squaring.
   function automatic logic [W-1:0] term(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [W-1:0] diff;
      logic [W-1:0] r;
      diff = (a >= b) ? (a - b) : (b - a);
      case (op)
         OP_PT:            r = a * b;
         OP_L2:            r = diff * diff;
         OP_MINP, OP_MAXP: r = sat_add(a, b);
         OP_MINMAX:        r = (a > b) ? a : b;
         OP_MAXMIN:        r = (a < b) ? a : b;
         OP_ORAND:         r = a & b;
         default:          r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] combine(input logic [2:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      logic [W-1:0] r;
      case (op)
         OP_PT, OP_L2:        r = x + y;
         OP_MINP, OP_MINMAX:  r = (x < y) ? x : y;
         OP_MAXP, OP_MAXMIN:  r = (x > y) ? x : y;
         OP_ORAND:            r = x | y;
         default:             r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] identity(input logic [2:0] op);
      return (op == OP_MINP || op == OP_MINMAX) ? INF : '0;
   endfunction

   logic            en;

   logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [VW-1:0]   a1_q, a1_d, b1_q, b1_d, c1_q, c1_d;
   logic [2:0]      op1_q, op1_d, op2_q, op2_d;
   logic            acc1_q, acc1_d;
   logic [W-1:0]    t2_q [NNN];
   logic [W-1:0]    t2_d [NNN];
   logic [W-1:0]    c2_q [NN];
   logic [W-1:0]    c2_d [NN];
   logic [VW-1:0]   d3_q, d3_d;
   logic            err3_q, err3_d;

   // Only a result held by the consumer stalls; every stage advances together.
   assign en            = !(v3_q && !bus.out_ready);
   assign bus.in_ready  = en;
   assign bus.out_valid = v3_q;
   assign bus.out       = d3_q;
   assign bus.out_err   = err3_q;

   // S1: operand capture
   always_comb begin
      v1_d   = v1_q;
      a1_d   = a1_q;
      b1_d   = b1_q;
      c1_d   = c1_q;
      op1_d  = op1_q;
      acc1_d = acc1_q;
      if (en) begin
         v1_d   = bus.in_valid;
         a1_d   = bus.inA;
         b1_d   = bus.inB;
         c1_d   = bus.inC;
         op1_d  = bus.op;
         acc1_d = bus.acc_en;
      end
   end

   // S2: pairwise terms t[i][j][k] = a[i][k] (x) b[k][j], plus resolved c'
   always_comb begin
      v2_d  = v2_q;
      op2_d = op2_q;
      t2_d  = t2_q;
      c2_d  = c2_q;
      if (en) begin
         v2_d  = v1_q;
         op2_d = op1_q;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               c2_d[i*N+j] = acc1_q ? c1_q[(i*N+j)*W +: W] : identity(op1_q);
               for (int k = 0; k < N; k++) begin
                  t2_d[(i*N+j)*N+k] = term(op1_q, a1_q[(i*N+k)*W +: W], b1_q[(k*N+j)*W +: W]);
               end
            end
         end
      end
   end

   // S3: reduction over k, seeded with c'
   always_comb begin
      logic [W-1:0] acc_v;
      acc_v  = '0;
      v3_d   = v3_q;
      d3_d   = d3_q;
      err3_d = err3_q;
      if (en) begin
         v3_d   = v2_q;
         err3_d = (op2_q == OP_RSV);
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_v = c2_q[i*N+j];
               for (int k = 0; k < N; k++) begin
                  acc_v = combine(op2_q, acc_v, t2_q[(i*N+j)*N+k]);
               end
               d3_d[(i*N+j)*W +: W] = (op2_q == OP_RSV) ? '0 : acc_v;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         a1_q   <= '0;
         b1_q   <= '0;
         c1_q   <= '0;
         op1_q  <= '0;
         acc1_q <= 1'b0;
         op2_q  <= '0;
         for (int n = 0; n < NNN; n++) t2_q[n] <= '0;
         for (int n = 0; n < NN; n++)  c2_q[n] <= '0;
         d3_q   <= '0;
         err3_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         a1_q   <= a1_d;
         b1_q   <= b1_d;
         c1_q   <= c1_d;
         op1_q  <= op1_d;
         acc1_q <= acc1_d;
         op2_q  <= op2_d;
         t2_q   <= t2_d;
         c2_q   <= c2_d;
         d3_q   <= d3_d;
         err3_q <= err3_d;
      end
   end

`ifdef ETC_PERF_CNT_EN
   logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;

   always_comb begin
      perf_ops_d   = perf_ops_q + ((v3_q && bus.out_ready) ? 32'd1 : 32'd0);
      perf_stall_d = perf_stall_q + ((v3_q && !bus.out_ready) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_ops_q   <= perf_ops_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_etc_semiring_pipe.sv
// tb_etc_semiring_pipe
//    Directed bench for etc_semiring_pipe (W=16, N=4). Expected results come
//    from a plain-arithmetic semiring model queued on each input transfer and
//    compared on each output transfer; a few literal values pin the model.
module tb_etc_semiring_pipe;
   localparam int W  = 16;
   localparam int N  = 4;
   localparam int VW = N * N * W;
   localparam longint INF = 65535;

   typedef logic [VW-1:0] mat_t;
   typedef struct packed {
      mat_t d;
      logic err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   etc_semiring_pipe_if #(.W(W), .N(N)) bus ();

`ifdef ETC_PERF_CNT_EN
   logic [31:0] perf_ops, perf_stall;
`endif

   etc_semiring_pipe #(.W(W), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ETC_PERF_CNT_EN
      ,
      .perf_ops   (perf_ops),
      .perf_stall (perf_stall)
`endif
   );

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   n_out = 0;
   int   n_stall = 0;
   exp_t exp_q[$];
   bit   held = 0;
   mat_t held_out;
   mat_t last_out;

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic longint get(input mat_t m, input int i, input int j);
      return longint'(m[(i*N+j)*W +: W]);
   endfunction

   function automatic mat_t put(input mat_t m, input int i, input int j, input longint v);
      mat_t r;
      r = m;
      r[(i*N+j)*W +: W] = v[W-1:0];
      return r;
   endfunction

   function automatic longint sat(input longint x, input longint y);
      if (x == INF || y == INF || x + y > INF) return INF;
      return x + y;
   endfunction

   function automatic longint mn(input longint x, input longint y);
      return (x < y) ? x : y;
   endfunction

   function automatic longint mx(input longint x, input longint y);
      return (x > y) ? x : y;
   endfunction

   // Reference: D[i][j] = c' (+) sum_k a[i][k] (x) b[k][j], evaluated in wide integers.
   function automatic mat_t model(input int op, input bit acc, input mat_t A, input mat_t B,
                                  input mat_t C, output bit err);
      mat_t   d;
      longint r, x, y;
      d   = '0;
      err = (op == 7);
      if (err) return d;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (acc) r = get(C, i, j);
            else r = (op == 2 || op == 4) ? INF : 0;
            for (int k = 0; k < N; k++) begin
               x = get(A, i, k);
               y = get(B, k, j);
               case (op)
                  0: r = r + x * y;
                  1: r = r + (x - y) * (x - y);
                  2: r = mn(r, sat(x, y));
                  3: r = mx(r, sat(x, y));
                  4: r = mn(r, mx(x, y));
                  5: r = mx(r, mn(x, y));
                  default: r = r | (x & y);
               endcase
            end
            d = put(d, i, j, r % 65536);
         end
      end
      return d;
   endfunction

   function automatic mat_t gen(input int s);
      mat_t m;
      m = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            m = put(m, i, j, longint'((s * 4099 + i * 613 + j * 977 + i * j * 31) & 16'hFFFF));
      m = put(m, 0, 0, INF);
      m = put(m, 1, 1, 65280 + s);
      return m;
   endfunction

   // Monitor: sampled on the falling edge, inputs only change just after rising edges.
   always @(negedge clk) begin
      exp_t e;
      bit   eb;
      if (!rst_n) begin
         exp_q.delete();
         held = 0;
      end else begin
         if (held) chk("hold_stable", bus.out, held_out);
         if (bus.out_valid && !bus.out_ready) begin
            chk("in_ready_stall", bus.in_ready, 0);
            held     = 1;
            held_out = bus.out;
            n_stall++;
         end else begin
            held = 0;
         end
         if (bus.in_valid && bus.in_ready) begin
            e.d   = model(int'(bus.op), bus.acc_en, bus.inA, bus.inB, bus.inC, eb);
            e.err = eb;
            exp_q.push_back(e);
         end
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            last_out = bus.out;
            if (exp_q.size() == 0) begin
               chk("unexpected_out", bus.out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", bus.out, e.d);
               chk("out_err", bus.out_err, e.err);
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input bit acc, input mat_t A, input mat_t B,
                       input mat_t C);
      bit rdy;
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.acc_en   = acc;
      bus.inA      = A;
      bus.inB      = B;
      bus.inC      = C;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) return;
      end
      chk("send_timeout", 1, 0);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 100; n++) begin
         if (exp_q.size() == 0) return;
         @(posedge clk);
         #1;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      mat_t ident, bmat, junk, rmat, c5, la, lb, d;
      bit   e;
      int   base;

      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.acc_en    = 1'b0;
      bus.inA       = '0;
      bus.inB       = '0;
      bus.inC       = '0;
      bus.out_ready = 1'b1;

      ident = '0;
      bmat  = '0;
      rmat  = '0;
      c5    = '0;
      la    = '0;
      lb    = '0;
      junk  = gen(9);
      for (int i = 0; i < N; i++) begin
         ident = put(ident, i, i, 1);
         for (int j = 0; j < N; j++) begin
            bmat = put(bmat, i, j, i * 4 + j);
            c5   = put(c5, i, j, 5);
         end
         rmat = put(rmat, i, 0, 0);
         rmat = put(rmat, i, 1, 3);
         rmat = put(rmat, i, 2, INF);
         rmat = put(rmat, i, 3, 7);
      end
      la = put(la, 0, 0, 1); la = put(la, 0, 1, 2); la = put(la, 1, 0, 3); la = put(la, 1, 1, 4);
      lb = put(lb, 0, 0, 1); lb = put(lb, 0, 1, 5); lb = put(lb, 1, 0, 2); lb = put(lb, 1, 1, 6);

      // Reset state
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out", bus.out, '0);
      chk("rst_out_err", bus.out_err, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
`ifdef ETC_PERF_CNT_EN
      chk("rst_perf_ops", perf_ops, 0);
      chk("rst_perf_stall", perf_stall, 0);
`endif

      // Pin the model with hand-computed values
      d = model(0, 0, ident, bmat, junk, e);
      chk("pin_pt", d, bmat);
      d = model(2, 1, rmat, rmat, c5, e);
      chk("pin_mp00", get(d, 0, 0), 0);
      chk("pin_mp01", get(d, 0, 1), 3);
      chk("pin_mp02", get(d, 0, 2), 5);
      chk("pin_mp03", get(d, 3, 3), 5);
      d = model(1, 0, la, lb, junk, e);
      chk("pin_l2_00", get(d, 0, 0), 0);
      chk("pin_l2_01", get(d, 0, 1), 32);
      chk("pin_l2_10", get(d, 1, 0), 8);
      chk("pin_l2_11", get(d, 1, 1), 8);
      d = model(7, 1, junk, junk, junk, e);
      chk("pin_rsv", {d, e}, {mat_t'(0), 1'b1});

      // Plus-times with exact latency
      send(3'b000, 1'b0, ident, bmat, junk);
      idle();
      chk("lat_c1", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("lat_c2", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("lat_c3", bus.out_valid, 1);
      chk("lat_out", bus.out, bmat);
      chk("lat_err", bus.out_err, 0);
      drain();

      // Min-plus with accumulate
      send(3'b010, 1'b1, rmat, rmat, c5);
      idle();
      drain();
      @(negedge clk);
      chk("mp_dut_00", get(last_out, 0, 0), 0);
      chk("mp_dut_02", get(last_out, 2, 2), 5);

      // L2, 2x2 problem zero-padded into the 4x4 array
      send(3'b001, 1'b0, la, lb, junk);
      idle();
      drain();
      @(negedge clk);
      chk("l2_dut_00", get(last_out, 0, 0), 0);
      chk("l2_dut_01", get(last_out, 0, 1), 32);
      chk("l2_dut_10", get(last_out, 1, 0), 8);
      chk("l2_dut_11", get(last_out, 1, 1), 8);

      // Reserved op between two plus-times ops
      send(3'b000, 1'b1, gen(1), gen(2), gen(3));
      send(3'b111, 1'b1, gen(4), gen(5), gen(6));
      send(3'b000, 1'b0, gen(7), gen(8), gen(9));
      idle();
      drain();

      // Backpressure: 6 back-to-back ops, consumer holds for 4 cycles
      base    = n_out;
      n_stall = 0;
      fork
         begin
            send(3'b010, 1'b1, gen(11), gen(12), gen(13));
            send(3'b011, 1'b1, gen(14), gen(15), gen(16));
            send(3'b100, 1'b0, gen(17), gen(18), gen(19));
            send(3'b101, 1'b1, gen(20), gen(21), gen(22));
            send(3'b110, 1'b1, gen(23), gen(24), gen(25));
            send(3'b001, 1'b1, gen(26), gen(27), gen(28));
            idle();
         end
         begin
            for (int n = 0; n < 50; n++) begin
               @(posedge clk); #1;
               if (bus.out_valid) break;
            end
            bus.out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", n_out - base, 6);
      chk("bp_stalls", n_stall, 4);
`ifdef ETC_PERF_CNT_EN
      chk("perf_ops", perf_ops, n_out);
      chk("perf_stall", perf_stall, 4);
`endif

      // Reset with three ops in flight
      send(3'b000, 1'b0, gen(30), gen(31), gen(32));
      send(3'b011, 1'b0, gen(33), gen(34), gen(35));
      send(3'b101, 1'b0, gen(36), gen(37), gen(38));
      idle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_ready", bus.in_ready, 1);
`ifdef ETC_PERF_CNT_EN
      chk("post_rst_perf_ops", perf_ops, 0);
`endif
      base = n_out;
      repeat (10) @(posedge clk);
      #1;
      chk("no_stale", n_out - base, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/etc_semiring_pipe.md
Name: etc_semiring_pipe

Overview:
- Parametrised successor to the fixed 4x4 extended tensor core.
- Computes an NxN matrix operation D = C (+) (A (x) B) over a selectable semiring, or a squared-L2 distance, on W-bit unsigned elements.
- Three-stage pipeline with valid/ready handshakes on input and output, full backpressure, and an optional C accumulate path.
- Sits between the operand staging buffers and the result writeback in the extended-tensor-core datapath.

Parameters:
- W, 16, element width in bits (unsigned).
- N, 4, matrix dimension (N>=2); arrays are NxN, row-major, element [i][j] at bit offset (i*N+j)*W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands this cycle.
- op  in  3  operation select, sampled with operands.
- acc_en  in  1  1: combine with C; 0: C treated as semiring identity.
- inA  in  N*N*W  matrix A.
- inB  in  N*N*W  matrix B.
- inC  in  N*N*W  matrix C.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  N*N*W  result matrix D.
- out_err  out  1  result belongs to a reserved op.

Behaviour:
- Transfer: an input is accepted when in_valid && in_ready; an output is accepted when out_valid && out_ready.
- Pipeline: S1 registers A, B, C, op, acc_en. S2 registers all N^3 pairwise terms t[i][j][k] = a[i][k] (x) b[k][j]. S3 registers the reduction D[i][j] = c' (+) t[i][j][0] (+) ... (+) t[i][j][N-1].
- Latency: exactly 3 cycles from acceptance to out_valid, with no stall.
- Throughput: 1 result per cycle.
- Stall: global advance enable en = !(out_valid && !out_ready).
  - in_ready = en (combinational).
  - While en=0, all stage registers and valid bits hold, and out/out_err stay stable.
- Stage valid bits v1..v3 shift when en=1; out_valid = v3.
- Data registers of invalid stages may update and are don't-care, but out must be stable whenever out_valid=1.
- Ops, with INF = 2^W-1:
  - 000 plus-times: (x)=*, (+)=+, both mod 2^W; identity 0.
  - 001 L2: t = (a[i][k]-b[k][j])^2 mod 2^W using absolute difference; (+)=+ mod 2^W; identity 0. Full matrix, not triangular.
  - 010 min-plus: (x)=saturating + (result INF if either operand is INF or on overflow); (+)=min; identity INF.
  - 011 max-plus: (x)=saturating +; (+)=max; identity 0.
  - 100 min-max: (x)=max; (+)=min; identity INF.
  - 101 max-min: (x)=min; (+)=max; identity 0.
  - 110 or-and: (x)=bitwise AND; (+)=bitwise OR; identity 0.
  - 111 reserved: out = 0, out_err = 1.
- Accumulate: c' = C[i][j] if acc_en, else the op identity.
- Reset (rst_n=0, async): v1=v2=v3=0, out_valid=0, out=0, out_err=0. in_ready=1 once reset is deasserted.
- Reset mid-operation: all in-flight results are discarded and never presented.
- Simultaneous events: at full occupancy, output acceptance and input acceptance in the same cycle are both legal and lose no data.

Optional Feature:
- ETC_PERF_CNT_EN: adds output ports perf_ops (32) and perf_stall (32), both async-reset to 0.
  - perf_ops increments on each output transfer.
  - perf_stall increments each cycle with out_valid && !out_ready.
  - Both wrap at 2^32.
- Without the macro, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Plus-times, N=4, W=16, A=identity, B[i][j]=i*4+j, acc_en=0, out_ready=1 -> out=B, out_valid rises exactly 3 cycles after acceptance, out_err=0.
- Min-plus, N=4: A/B rows {0,3,INF,7}, acc_en=1, C=all 5 -> each D = min(5, finite saturated sums); any INF operand yields INF; D[0][0] = min(5, 0+0) = 0.
- L2, N=2: A=[[1,2],[3,4]], B=[[1,5],[2,6]] -> D = [[(0)^2+(0)^2, (4)^2+(4)^2], [(2)^2+(2)^2, (2)^2+(2)^2]] = [[0,32],[8,8]]. Check the squared absolute-difference path, including unsigned underflow avoidance.
- Backpressure: stream 6 back-to-back ops, hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 during the hold, out stable, all 6 results in order with none lost or duplicated.
- Reserved op 111 interleaved between two plus-times ops -> that result has out=0, out_err=1; neighbours are correct with out_err=0.
- Assert rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0 immediately, no stale result afterwards; ETC_PERF_CNT_EN build shows perf_ops=0.
